// File: rtl/symbolic_qkd_pkg.sv
// Shared types for the symbolic QKD reader: FSM states, key status codes, request metadata.
package symbolic_qkd_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_READ,
      ST_CHECK,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      KEY_OK        = 2'd0,
      KEY_EXHAUSTED = 2'd1,
      KEY_TAMPER    = 2'd2
   } key_status_e;

   typedef struct packed {
      logic [1:0] basis;
      logic [1:0] phase;
      logic [3:0] identity;
   } req_meta_t;

endpackage

// File: rtl/symbolic_qkd_key_assembler.sv
// Key byte-slot storage with clear, and a registered key output that reads zero unless published OK.
module symbolic_qkd_key_assembler
   import symbolic_qkd_pkg::*;
#(
   parameter int unsigned KEY_BYTES = 4,
   parameter int unsigned SLOT_W    = $clog2(KEY_BYTES + 1)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear_i,
   input  logic                        wr_en_i,
   input  logic [SLOT_W-1:0]           slot_i,
   input  logic [BYTE_W-1:0]           byte_i,
   input  logic                        show_i,
   output logic [BYTE_W*KEY_BYTES-1:0] key_data_o
);

   logic [BYTE_W*KEY_BYTES-1:0] key_q, key_d;
   logic [BYTE_W*KEY_BYTES-1:0] out_q;

   always_comb begin
      key_d = key_q;
      if (clear_i) begin
         key_d = '0;
      end else begin
         for (int unsigned k = 0; k < KEY_BYTES; k++) begin
            if (wr_en_i && slot_i == SLOT_W'(k)) key_d[k*BYTE_W +: BYTE_W] = byte_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q <= '0;
         out_q <= '0;
      end else begin
         key_q <= key_d;
         out_q <= show_i ? key_q : '0;
      end
   end

   assign key_data_o = out_q;

endmodule

// File: rtl/symbolic_qkd_reader.sv
// Reader-side sifting controller for a bank of read-once symbolic QKD cells.
// Optional SYMBOLIC_QKD_READER_FUSE_CHECK_EN: treat a missing or stray collapse fuse pulse as tamper.
module symbolic_qkd_reader
   import symbolic_qkd_pkg::*;
#(
   parameter int unsigned N_CELLS   = 16,
   parameter int unsigned KEY_BYTES = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [1:0]                  req_basis,
   input  logic [1:0]                  req_phase,
   input  logic [3:0]                  req_identity,
   output logic                        reg_init,
   output logic [N_CELLS-1:0]          reg_read,
   output logic [1:0]                  reg_basis,
   output logic [1:0]                  reg_phase,
   output logic [3:0]                  reg_identity,
   input  logic [BYTE_W*N_CELLS-1:0]   reg_value,
   input  logic [N_CELLS-1:0]          reg_oe,
   input  logic [N_CELLS-1:0]          reg_fuse_fire,
   output logic                        reg_fuse_blow,
   output logic                        key_valid,
   input  logic                        key_ready,
   output logic [BYTE_W*KEY_BYTES-1:0] key_data,
   output logic [1:0]                  key_status,
   output logic [7:0]                  rej_count
);

   localparam int unsigned PTR_W = $clog2(N_CELLS + 1);
   localparam int unsigned IDX_W = $clog2(N_CELLS);
   localparam int unsigned CNT_W = $clog2(KEY_BYTES + 1);

   state_e             state_q, state_d;
   key_status_e        status_q, status_d;
   req_meta_t          meta_q, meta_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         rej_q, rej_d;
   logic               acc_q, acc_d;
   logic               tamper_q, tamper_d;
   logic               req_ready_q, reg_init_q, key_valid_q;
   logic [N_CELLS-1:0] reg_read_q;

   logic [IDX_W-1:0]   idx;
   logic [N_CELLS-1:0] sel, sel_d;
   logic               stray_oe, fuse_bad, key_clear, key_wr;

   assign idx      = ptr_q[IDX_W-1:0];
   assign sel      = N_CELLS'(1) << idx;
   assign sel_d    = N_CELLS'(1) << ptr_d[IDX_W-1:0];
   assign stray_oe = |(reg_oe & ~sel);

`ifdef SYMBOLIC_QKD_READER_FUSE_CHECK_EN
   assign fuse_bad = !reg_fuse_fire[idx] || (|(reg_fuse_fire & ~sel));
`else
   logic unused_fuse;
   assign unused_fuse = ^reg_fuse_fire;
   assign fuse_bad    = 1'b0;
`endif

   // Next-state and datapath control
   always_comb begin
      state_d   = state_q;
      status_d  = status_q;
      meta_d    = meta_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      rej_d     = rej_q;
      acc_d     = acc_q;
      tamper_d  = tamper_q;
      key_clear = 1'b0;
      key_wr    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               meta_d = '{basis: req_basis, phase: req_phase, identity: req_identity};
               if (tamper_q) begin
                  state_d  = ST_DONE;
                  status_d = KEY_TAMPER;
               end else if (ptr_q == PTR_W'(N_CELLS)) begin
                  state_d  = ST_DONE;
                  status_d = KEY_EXHAUSTED;
               end else begin
                  state_d   = ST_INIT;
                  cnt_d     = '0;
                  key_clear = 1'b1;
               end
            end
         end
         ST_INIT: state_d = ST_READ;
         ST_READ: begin
            acc_d  = reg_oe[idx];
            key_wr = reg_oe[idx];
            if (stray_oe) begin
               state_d  = ST_DONE;
               status_d = KEY_TAMPER;
               tamper_d = 1'b1;
            end else begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            ptr_d = ptr_q + PTR_W'(1);
            if (acc_q)               cnt_d = cnt_q + CNT_W'(1);
            else if (rej_q != 8'hFF) rej_d = rej_q + 8'd1;
            if (fuse_bad) begin
               state_d  = ST_DONE;
               status_d = KEY_TAMPER;
               tamper_d = 1'b1;
            end else if (cnt_d == CNT_W'(KEY_BYTES)) begin
               state_d  = ST_DONE;
               status_d = KEY_OK;
            end else if (ptr_d == PTR_W'(N_CELLS)) begin
               state_d  = ST_DONE;
               status_d = KEY_EXHAUSTED;
            end else begin
               state_d = ST_READ;
            end
         end
         ST_DONE: begin
            if (key_ready) begin
               state_d  = ST_IDLE;
               status_d = KEY_OK;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         status_q    <= KEY_OK;
         meta_q      <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         rej_q       <= '0;
         acc_q       <= 1'b0;
         tamper_q    <= 1'b0;
         req_ready_q <= 1'b0;
         reg_init_q  <= 1'b0;
         reg_read_q  <= '0;
         key_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         status_q    <= status_d;
         meta_q      <= meta_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         rej_q       <= rej_d;
         acc_q       <= acc_d;
         tamper_q    <= tamper_d;
         req_ready_q <= (state_d == ST_IDLE);
         reg_init_q  <= (state_d == ST_INIT);
         reg_read_q  <= (state_d == ST_READ) ? sel_d : '0;
         key_valid_q <= (state_d == ST_DONE);
      end
   end

   symbolic_qkd_key_assembler #(
      .KEY_BYTES (KEY_BYTES),
      .SLOT_W    (CNT_W)
   ) u_key (
      .clk        (clk),
      .rst_n      (reset_n),
      .clear_i    (key_clear),
      .wr_en_i    (key_wr),
      .slot_i     (cnt_q),
      .byte_i     (reg_value[idx*BYTE_W +: BYTE_W]),
      .show_i     ((state_d == ST_DONE) && (status_d == KEY_OK)),
      .key_data_o (key_data)
   );

   assign req_ready     = req_ready_q;
   assign reg_init      = reg_init_q;
   assign reg_read      = reg_read_q;
   assign reg_basis     = meta_q.basis;
   assign reg_phase     = meta_q.phase;
   assign reg_identity  = meta_q.identity;
   assign reg_fuse_blow = tamper_q;
   assign key_valid     = key_valid_q;
   assign key_status    = status_q;
   assign rej_count     = rej_q;

endmodule

// File: tb/tb_symbolic_qkd_reader.sv
// Directed bench for symbolic_qkd_reader with a simple cell-bank model (oe on authorized read, fuse pulse one cycle later).
module tb_symbolic_qkd_reader;

   logic         clk, reset_n;
   logic         req_valid, req_ready;
   logic [1:0]   req_basis, req_phase;
   logic [3:0]   req_identity;
   logic         reg_init;
   logic [15:0]  reg_read;
   logic [1:0]   reg_basis, reg_phase;
   logic [3:0]   reg_identity;
   logic [127:0] reg_value;
   logic [15:0]  reg_oe, reg_fuse_fire;
   logic         reg_fuse_blow, key_valid, key_ready;
   logic [31:0]  key_data;
   logic [1:0]   key_status;
   logic [7:0]   rej_count;

   logic [15:0]  auth, stray, fuse_sup;
   int           n_checks = 0;
   int           n_errors = 0;
   int           lat, inits;
   logic [15:0]  rd2;
   logic         stable;

   symbolic_qkd_reader dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_basis     (req_basis),
      .req_phase     (req_phase),
      .req_identity  (req_identity),
      .reg_init      (reg_init),
      .reg_read      (reg_read),
      .reg_basis     (reg_basis),
      .reg_phase     (reg_phase),
      .reg_identity  (reg_identity),
      .reg_value     (reg_value),
      .reg_oe        (reg_oe),
      .reg_fuse_fire (reg_fuse_fire),
      .reg_fuse_blow (reg_fuse_blow),
      .key_valid     (key_valid),
      .key_ready     (key_ready),
      .key_data      (key_data),
      .key_status    (key_status),
      .rej_count     (rej_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cell bank model: authorized cells enable output while strobed; fuse pulses the cycle after
   assign reg_oe = (reg_read & auth) | stray;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) reg_fuse_fire <= '0;
      else          reg_fuse_fire <= reg_read & ~fuse_sup;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic issue_req(input logic [1:0] b, input logic [1:0] p, input logic [3:0] id);
      int g = 0;
      while (!req_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      check("req_ready", req_ready, 1);
      req_valid    = 1'b1;
      req_basis    = b;
      req_phase    = p;
      req_identity = id;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_key(output int l, output int n_init, output logic [15:0] r2);
      l = 1;
      n_init = 0;
      r2 = '0;
      while (!key_valid && l < 200) begin
         if (reg_init) n_init++;
         @(negedge clk);
         l++;
         if (l == 2) r2 = reg_read;
      end
      check("key_valid_seen", key_valid, 1);
   endtask

   task automatic ack();
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      check("ack_req_ready", req_ready, 1);
      check("ack_key_valid", key_valid, 0);
   endtask

   initial begin
      reset_n = 1'b0; req_valid = 1'b0; key_ready = 1'b0;
      req_basis = '0; req_phase = '0; req_identity = '0;
      auth = '0; stray = '0; fuse_sup = '0;
      for (int i = 0; i < 16; i++) reg_value[8*i +: 8] = 8'hA0 + 8'(i);

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_reg_init", reg_init, 0);
      check("rst_reg_read", reg_read, 0);
      check("rst_key_valid", key_valid, 0);
      check("rst_status", key_status, 0);
      check("rst_key_data", key_data, 0);
      check("rst_rej_fuse", {rej_count, reg_fuse_blow}, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_ready", req_ready, 1);

      // All cells authorized: first four cells form the key
      auth = 16'hFFFF;
      issue_req(2'd2, 2'd1, 4'hA);
      check("meta", {reg_basis, reg_phase, reg_identity}, {2'd2, 2'd1, 4'hA});
      wait_key(lat, inits, rd2);
      check("a_lat", lat, 10);
      check("a_inits", inits, 1);
      check("a_read_c2", rd2, 16'h0001);
      check("a_status", key_status, 0);
      check("a_key", key_data, 32'hA3A2A1A0);
      check("a_rej", rej_count, 0);
      check("a_blow", reg_fuse_blow, 0);
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         stable &= key_valid && (key_data == 32'hA3A2A1A0) && (key_status == 2'd0) && !req_ready;
      end
      check("a_hold_stable", stable, 1);
      ack();
      issue_req(2'd0, 2'd0, 4'h0);
      wait_key(lat, inits, rd2);
      check("a2_lat", lat, 10);
      check("a2_key", key_data, 32'hA7A6A5A4);
      ack();

      // Cells 1,5,6,9 authorized
      do_reset();
      auth = 16'h0262;
      issue_req(2'd1, 2'd3, 4'h5);
      wait_key(lat, inits, rd2);
      check("b_lat", lat, 22);
      check("b_status", key_status, 0);
      check("b_key", key_data, 32'hA9A6A5A1);
      check("b_rej", rej_count, 6);
      ack();

      // Only three authorized cells: bank runs dry
      do_reset();
      auth = 16'h1084;
      issue_req(2'd3, 2'd0, 4'h7);
      wait_key(lat, inits, rd2);
      check("c_lat", lat, 34);
      check("c_status", key_status, 1);
      check("c_key", key_data, 0);
      check("c_rej", rej_count, 13);
      ack();
      issue_req(2'd3, 2'd0, 4'h7);
      wait_key(lat, inits, rd2);
      check("c2_lat", lat, 1);
      check("c2_inits", inits, 0);
      check("c2_status", key_status, 1);
      ack();

      // Missing fuse pulse on cell 2
      do_reset();
      auth = 16'hFFFF;
      fuse_sup = 16'h0004;
      issue_req(2'd0, 2'd1, 4'h3);
      wait_key(lat, inits, rd2);
`ifdef SYMBOLIC_QKD_READER_FUSE_CHECK_EN
      check("d_lat", lat, 8);
      check("d_status", key_status, 2);
      check("d_key", key_data, 0);
      check("d_blow", reg_fuse_blow, 1);
      ack();
      check("d_blow_sticky", reg_fuse_blow, 1);
      issue_req(2'd0, 2'd1, 4'h3);
      wait_key(lat, inits, rd2);
      check("d2_lat", lat, 1);
      check("d2_inits", inits, 0);
      check("d2_status", key_status, 2);
      ack();
`else
      check("d_lat", lat, 10);
      check("d_status", key_status, 0);
      check("d_key", key_data, 32'hA3A2A1A0);
      check("d_blow", reg_fuse_blow, 0);
      ack();
`endif
      fuse_sup = '0;

      // Stray output-enable on cell 10 during the read of cell 0
      do_reset();
      stray = 16'h0400;
      issue_req(2'd1, 2'd1, 4'h1);
      wait_key(lat, inits, rd2);
      check("e_lat", lat, 3);
      check("e_status", key_status, 2);
      check("e_key", key_data, 0);
      check("e_blow", reg_fuse_blow, 1);
      ack();
      stray = '0;

      // Reset during the read of cell 2
      do_reset();
      issue_req(2'd2, 2'd2, 4'hC);
      for (int g = 0; g < 20 && reg_read != 16'h0004; g++) @(negedge clk);
      check("g_read2_seen", reg_read, 16'h0004);
      reset_n = 1'b0;
      #1;
      check("g_rst_outs", {req_ready, reg_init, reg_read, key_valid, key_status, rej_count,
                           reg_fuse_blow, reg_basis, reg_phase, reg_identity}, 0);
      check("g_rst_key", key_data, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      issue_req(2'd2, 2'd2, 4'hC);
      wait_key(lat, inits, rd2);
      check("g_read_c2", rd2, 16'h0001);
      check("g_key", key_data, 32'hA3A2A1A0);
      ack();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/symbolic_qkd_reader.md
# symbolic_qkd_reader

Reader-side sifting controller that sits directly downstream of a bank of N_CELLS read-once symbolic QKD register cells. On a key request it provisions the bank, issues exactly one read strobe per cell with the requester's basis, phase and identity, and captures bytes only when the cell's logical output-enable confirms authorization. It assembles KEY_BYTES accepted bytes into a key and checks each cell's collapse fuse pulse as a tamper-integrity signal.

## Interface
- N_CELLS, 16: register cells in the bank (2..64).
- KEY_BYTES, 4: accepted bytes per key (1..N_CELLS).
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  key request.
- req_ready  out  1  high only in IDLE.
- req_basis  in  2  reader basis.
- req_phase  in  2  reader phase.
- req_identity  in  4  reader identity.
- reg_init  out  1  broadcast init pulse to all cells.
- reg_read  out  N_CELLS  one-hot read strobe.
- reg_basis / reg_phase / reg_identity  out  2/2/4  latched request metadata to all cells.
- reg_value  in  8*N_CELLS  cell value_out, cell i at [8i+7:8i].
- reg_oe  in  N_CELLS  cell output_enable.
- reg_fuse_fire  in  N_CELLS  cell fuse_fire.
- reg_fuse_blow  out  1  broadcast tamper kill, sticky.
- key_valid  out  1  result valid; held until key_ready.
- key_ready  in  1  consumer accept.
- key_data  out  8*KEY_BYTES  first accepted byte in [7:0].
- key_status  out  2  0 OK, 1 EXHAUSTED, 2 TAMPER.
- rej_count  out  8  saturating count of rejected cells.

## Operation
- States: IDLE, INIT, READ, CHECK, DONE.
- IDLE: req_ready=1; on req_valid latch metadata. If tamper flag set -> DONE/TAMPER; else if cell pointer == N_CELLS -> DONE/EXHAUSTED; else -> INIT, clear byte count and key shift register.
- INIT: reg_init=1 one cycle -> READ.
- READ: reg_read[ptr]=1 one cycle. If reg_oe[ptr], capture reg_value byte ptr into key slot byte_count, mark accepted; else mark rejected. Any reg_oe[j], j!=ptr, high -> tamper. -> CHECK.
- CHECK: ptr++. Rejected -> rej_count++ (saturate at 255). Accepted -> byte_count++. If byte_count reaches KEY_BYTES -> DONE/OK; else if ptr == N_CELLS -> DONE/EXHAUSTED; else -> READ.
- DONE: key_valid=1; key_data and key_status stable until key_ready; then -> IDLE. key_data forced to 0 unless status OK.
- Cell pointer persists across requests: cells are single-use until reset_n.
- Tamper: status TAMPER, tamper flag and reg_fuse_blow set, both sticky until reset_n.

## Timing
- Reset values: req_ready=0 during reset, 1 in IDLE thereafter; all other outputs 0, pointer 0, tamper flag 0.
- Accept at edge 0; reg_init cycle 1; reg_read[0] cycle 2; CHECK cycle 3; 2 cycles per cell.
- Minimum latency: key_valid 2+2*KEY_BYTES cycles after accept edge (10 for defaults).
- Byte captured on the same edge the cell collapses; reg_value is never sampled in other cycles.
- reg_fuse_fire[ptr] is sampled in CHECK (cell's registered pulse, one cycle after the read).
- Tamper detected in READ or CHECK goes to DONE on the next edge, overriding accept/exhaust.
- reset_n mid-operation: immediate return to IDLE, partial key discarded.

## Configuration
- SYMBOLIC_QKD_READER_FUSE_CHECK_EN defined: in CHECK, reg_fuse_fire[ptr]==0 or any reg_fuse_fire[j], j!=ptr, ==1 -> tamper.
- Undefined: reg_fuse_fire ignored; only the stray-reg_oe check raises tamper.

## Structure
- Package symbolic_qkd_pkg: state enum, key_status enum (OK/EXHAUSTED/TAMPER), 8-bit byte width constant.
- Sub-module symbolic_qkd_key_assembler: byte-slot write, clear and zero-on-fail masking of key_data.

## Test plan
- Matching metadata on all 16 cells, KEY_BYTES=4: key_valid at cycle 10, status OK, key_data = cell bytes 3,2,1,0 in [31:24]..[7:0], ptr=4, rej_count=0.
- reg_oe high on cells 1,5,6,9 only: OK after cell 9, key_data holds those bytes, rej_count=6.
- reg_oe high on 3 cells in total: EXHAUSTED after cell 15, key_data=0, rej_count=13. A second request returns EXHAUSTED 1 cycle after accept, with no reg_init.
- With macro: suppress reg_fuse_fire on cell 2 -> TAMPER, reg_fuse_blow=1 sticky. A new request returns TAMPER. Without macro the same stimulus gives OK.
- key_ready held low 20 cycles in DONE: key_valid, key_data and key_status stable, req_ready=0. Then release -> IDLE next cycle.
- Deassert reset_n during READ of cell 2: all outputs 0, ptr=0. After release, a new request starts with reg_read[0].
